// File: rtl/core_bus_arb.sv
// core_bus_arb
//   Two-master (ibus, dbus) to one-slave Wishbone pipelined arbiter. Grants the
//   shared bus to one master at a time. dbus has priority, but a pending ibus
//   request wins once dbus has taken STARVE_LIMIT consecutive grants over it.
//   The arbiter counts accepted-but-unanswered transfers. It routes each
//   ack/err to the current owner and holds the grant until the owner has
//   dropped cyc and every outstanding transfer has been answered.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   i_*  (cyc/stb/we/adr/dat_w/sel in; dat_r/ack/err/stall out)  ibus master port
//   d_*  (same as i_*)                                             dbus master port
//   m_*  (cyc/stb/we/adr/dat_w/sel out; dat_r/ack/err/stall in)  shared slave bus
module core_bus_arb #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  // ibus
  input  logic            i_cyc,
  input  logic            i_stb,
  input  logic            i_we,
  input  logic [AW-1:0]   i_adr,
  input  logic [DW-1:0]   i_dat_w,
  input  logic [DW/8-1:0] i_sel,
  output logic [DW-1:0]   i_dat_r,
  output logic            i_ack,
  output logic            i_err,
  output logic            i_stall,
  // dbus
  input  logic            d_cyc,
  input  logic            d_stb,
  input  logic            d_we,
  input  logic [AW-1:0]   d_adr,
  input  logic [DW-1:0]   d_dat_w,
  input  logic [DW/8-1:0] d_sel,
  output logic [DW-1:0]   d_dat_r,
  output logic            d_ack,
  output logic            d_err,
  output logic            d_stall,
  // shared bus
  output logic            m_cyc,
  output logic            m_stb,
  output logic            m_we,
  output logic [AW-1:0]   m_adr,
  output logic [DW-1:0]   m_dat_w,
  output logic [DW/8-1:0] m_sel,
  input  logic [DW-1:0]   m_dat_r,
  input  logic            m_ack,
  input  logic            m_err,
  input  logic            m_stall
);

  localparam int OCW = $clog2(MAX_OUTST + 1);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t         r_state, w_next;
  logic [OCW-1:0] r_outst, w_outst_nxt;
  logic [SCW-1:0] r_starve, w_starve_nxt;

  logic w_own_cyc, w_own_stb;
  logic w_full, w_rsp_vld, w_ack, w_err, w_inc, w_dec;

  // Owner request mux; everything reads as zero while IDLE.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    m_we      = 1'b0;
    m_adr     = '0;
    m_dat_w   = '0;
    m_sel     = '0;
    case (r_state)
      GNT_I: begin
        w_own_cyc = i_cyc;
        w_own_stb = i_stb;
        m_we      = i_we;
        m_adr     = i_adr;
        m_dat_w   = i_dat_w;
        m_sel     = i_sel;
      end
      GNT_D: begin
        w_own_cyc = d_cyc;
        w_own_stb = d_stb;
        m_we      = d_we;
        m_adr     = d_adr;
        m_dat_w   = d_dat_w;
        m_sel     = d_sel;
      end
      default: ;
    endcase
  end

  assign w_full = (r_outst == OCW'(MAX_OUTST));

  // m_cyc stays up for the whole grant, including the drain phase after the
  // owner drops cyc, so late acks still find an open cycle.
  assign m_cyc = (r_state != IDLE);
  assign m_stb = m_cyc & w_own_cyc & w_own_stb & ~w_full;

  // A response with nothing outstanding is stray and gets dropped.
  // err wins over ack when the slave raises both.
  assign w_rsp_vld = (r_outst != '0);
  assign w_err     = m_err & w_rsp_vld;
  assign w_ack     = m_ack & ~m_err & w_rsp_vld;

  always_comb begin
    i_ack   = 1'b0;
    i_err   = 1'b0;
    i_stall = 1'b1;
    i_dat_r = '0;
    d_ack   = 1'b0;
    d_err   = 1'b0;
    d_stall = 1'b1;
    d_dat_r = '0;
    if (r_state == GNT_I) begin
      i_ack   = w_ack;
      i_err   = w_err;
      i_stall = m_stall | w_full;
      i_dat_r = m_dat_r;
    end
    if (r_state == GNT_D) begin
      d_ack   = w_ack;
      d_err   = w_err;
      d_stall = m_stall | w_full;
      d_dat_r = m_dat_r;
    end
  end

  // Outstanding transfer count
  assign w_inc = m_stb & ~m_stall;
  assign w_dec = (m_ack | m_err) & w_rsp_vld;

  always_comb begin
    case ({w_inc, w_dec})
      2'b10:   w_outst_nxt = r_outst + 1'b1;
      2'b01:   w_outst_nxt = r_outst - 1'b1;
      default: w_outst_nxt = r_outst;
    endcase
  end

  // Arbitration
  always_comb begin
    w_next       = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      IDLE: begin
        if (d_cyc && !(i_cyc && (r_starve >= SCW'(STARVE_LIMIT)))) begin
          w_next = GNT_D;
          // This branch with i_cyc set is only reachable below the limit,
          // so the increment saturates without an explicit clamp.
          if (i_cyc)
            w_starve_nxt = r_starve + 1'b1;
        end else if (i_cyc) begin
          w_next       = GNT_I;
          w_starve_nxt = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (!w_own_cyc && (r_outst == '0))
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_outst  <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_next;
      r_outst  <= w_outst_nxt;
      r_starve <= w_starve_nxt;
    end
  end

endmodule

// File: doc/core_bus_arb.md
Name: core_bus_arb

Overview:
- Two-master to one-slave Wishbone pipelined arbiter.
- Shares a single external memory bus between the instruction fetch port (ibus) and the load/store port (dbus) of the core.
- Sits between the core's ibus/dbus pl_master ports and the system bus.
- Tracks outstanding transfers, routes each ack/err to the owning master, and enforces bounded starvation.

Parameters:
AW, 32, address width
DW, 32, data width (SEL width = DW/8)
MAX_OUTST, 4, max accepted-but-unacknowledged transfers on the shared bus
STARVE_LIMIT, 4, consecutive dbus grants after which a pending ibus request wins

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
i_cyc, i_stb, i_we  in  1 each  ibus master cycle/strobe/write
i_adr  in  AW  ibus address
i_dat_w  in  DW  ibus write data
i_sel  in  DW/8  ibus byte select
i_dat_r  out  DW  ibus read data
i_ack, i_err, i_stall  out  1 each  ibus response/stall
d_cyc, d_stb, d_we, d_adr, d_dat_w, d_sel, d_dat_r, d_ack, d_err, d_stall  (same as i_*)  dbus port
m_cyc, m_stb, m_we  out  1 each  shared bus master
m_adr  out  AW  shared bus address
m_dat_w  out  DW  shared bus write data
m_sel  out  DW/8  shared bus byte select
m_dat_r  in  DW  shared bus read data
m_ack, m_err, m_stall  in  1 each  shared bus response/stall

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, outst=0, starve=0.
  - All m_* outputs 0.
  - i_ack/d_ack/i_err/d_err = 0; i_stall = d_stall = 1.
  - i_dat_r/d_dat_r = 0.
- States:
  - IDLE:
    - no requests -> stay in IDLE.
    - d_cyc & !(i_cyc & starve>=STARVE_LIMIT) -> GNT_D.
    - else i_cyc -> GNT_I.
    - Decision is registered; the first m_stb appears the cycle after the request (1-cycle arbitration latency).
  - GNT_I / GNT_D:
    - Owner's cyc/stb/we/adr/dat_w/sel pass combinationally to m_*; m_cyc=1.
    - Exit to IDLE when owner cyc=0 AND outst==0.
    - If owner drops cyc while outst>0, m_cyc stays 1 and m_stb=0 until drained (DRAIN handled within the grant state).
    - Ownership is never preempted mid-cycle.
- Outstanding counter outst (width clog2(MAX_OUTST+1)):
  - +1 on accepted strobe (m_stb & !m_stall).
  - -1 on m_ack | m_err.
  - Both in the same cycle -> unchanged.
  - outst==MAX_OUTST -> owner stall forced to 1 and m_stb forced to 0.
  - m_ack with outst==0 is ignored (not forwarded).
- Responses:
  - Owner's x_ack = m_ack, x_err = m_err, x_dat_r = m_dat_r, x_stall = m_stall | full.
  - Non-owner: ack=err=0, stall=1, dat_r=0.
  - m_ack and m_err both high -> err takes priority; ack suppressed.
- Starvation counter starve (saturating at STARVE_LIMIT):
  - Increments on each IDLE->GNT_D taken while i_cyc=1.
  - Clears on any IDLE->GNT_I.
  - Unchanged otherwise.
- Default priority: dbus over ibus.
- Simultaneous requests in IDLE with starve<STARVE_LIMIT -> dbus wins.
- Back-to-back: on an exit to IDLE, new arbitration happens next cycle. Max bus turnaround is 1 idle cycle between owners.

Test Plan:
- Only i_cyc with 3 pipelined reads, slave acks 2 cycles after each strobe:
  - m_stb is first seen 1 cycle after i_cyc.
  - 3 i_ack pulses with m_dat_r data.
  - d_ack never asserted; back to IDLE after last ack with i_cyc=0.
- i_cyc and d_cyc raised in the same cycle, 1 access each:
  - dbus granted first.
  - ibus granted 1 cycle after dbus cyc drops and outst=0.
  - starve=1, then cleared.
- ibus held requesting, dbus issues 5 single-access cycles back-to-back:
  - grants go D,D,D,D,I,D; ibus is never delayed past the 5th arbitration.
- Slave never acks, owner issues 6 strobes with m_stall=0:
  - exactly 4 accepted; owner stall=1 from then on.
  - after 1 ack, exactly 1 more strobe is accepted.
- Owner drops cyc with outst=2:
  - m_cyc stays 1 and m_stb=0 until 2 acks arrive.
  - other master waits; grant switches the cycle after drain.
- rst pulled low mid-transfer with outst=3:
  - all outputs return to reset values immediately (async).
  - on rst=1 the next request arbitrates from IDLE with outst=0.
  - m_err+m_ack together -> only err is delivered.
